// File: rtl/sbox_round_ctrl.sv
// sbox_round_ctrl: iterative substitution/rotation round engine.
// A single byte-wide s_box is time-shared over the four bytes of the block.
// Each round takes five cycles: four SUB cycles (one byte each) and one MIX
// cycle that rotates the block left by one byte.
// Optional feature macro: SBOX_ROUND_CTRL_KEY_EN
//   defined   -> MIX also XORs the block with the key latched at accept.
//   undefined -> MIX is a plain rotation; no key register is built.

// Byte substitution: swap the nibbles, then flip bit 0.
// It is a bijection, so no two input bytes share an output byte.
module s_box (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = {in_byte[3:0], in_byte[7:4]} ^ 8'h01;

endmodule

module sbox_round_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_rounds,
    input  logic [31:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] data_q;
    logic [31:0] data_next;
    logic [3:0]  count_q;
    logic [3:0]  count_next;
    logic [1:0]  idx_q;
    logic [1:0]  idx_next;

    logic [7:0]  sub_in;
    logic [7:0]  sub_out;
    logic [31:0] rotated;
    logic [31:0] mixed;

`ifdef SBOX_ROUND_CTRL_KEY_EN
    logic [31:0] key_q;
    logic [31:0] key_next;
`else
    logic        unused_key;
    assign unused_key = ^key;
`endif

    // The one substitution unit; the byte index selects which byte it sees.
    assign sub_in = data_q[{idx_q, 3'b000} +: 8];

    s_box u_s_box (
        .in_byte  (sub_in),
        .out_byte (sub_out)
    );

    assign rotated = {data_q[23:0], data_q[31:24]};

`ifdef SBOX_ROUND_CTRL_KEY_EN
    assign mixed = rotated ^ key_q;
`else
    assign mixed = rotated;
`endif

    // Next-state and datapath update logic for the round sequencer.
    always_comb begin
        state_next = state;
        data_next  = data_q;
        count_next = count_q;
        idx_next   = idx_q;
`ifdef SBOX_ROUND_CTRL_KEY_EN
        key_next   = key_q;
`endif
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_next  = in_data;
                    count_next = in_rounds;
                    idx_next   = 2'd0;
`ifdef SBOX_ROUND_CTRL_KEY_EN
                    key_next   = key;
`endif
                    if (in_rounds != 4'd0) begin
                        state_next = SUB;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SUB: begin
                data_next[{idx_q, 3'b000} +: 8] = sub_out;
                idx_next = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_next = MIX;
                end
            end
            MIX: begin
                data_next  = mixed;
                count_next = count_q - 4'd1;
                idx_next   = 2'd0;
                if (count_q == 4'd1) begin
                    state_next = DONE;
                end else begin
                    state_next = SUB;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and working block registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            data_q  <= 32'd0;
            count_q <= 4'd0;
            idx_q   <= 2'd0;
        end else begin
            state   <= state_next;
            data_q  <= data_next;
            count_q <= count_next;
            idx_q   <= idx_next;
        end
    end

`ifdef SBOX_ROUND_CTRL_KEY_EN
    // Key captured at accept and held for the whole block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q <= 32'd0;
        end else begin
            key_q <= key_next;
        end
    end
`endif

    // Registered handshake and status outputs, derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

    // Result register: loaded only when entering DONE so it holds afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= 32'd0;
        end else if ((state_next == DONE) && (state != DONE)) begin
            out_data <= data_next;
        end
    end

endmodule

// File: doc/sbox_round_ctrl.md
SBOX_ROUND_CTRL -- requirements
Module: sbox_round_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  block offered.
REQ-005 in_ready  output  1  block accepted on cycle where in_valid & in_ready.
REQ-006 in_data  input  32  plaintext block; byte i = in_data[8i+7:8i].
REQ-007 in_rounds  input  4  round count, sampled at accept; 0 = pass-through.
REQ-008 key  input  32  round key, sampled at accept.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  result consumed on cycle where out_valid & out_ready.
REQ-011 out_data  output  32  result block.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL instantiate exactly one s_box. It SHALL time-share that instance over all four bytes of all rounds.
REQ-014 FSM states: IDLE, SUB, MIX, DONE. All outputs registered.
REQ-015 IDLE: in_ready=1. On accept, latch data/key/rounds and clear byte index. Next state is SUB if in_rounds!=0, else DONE with data unchanged.
REQ-016 SUB: one byte per cycle, index 0..3. Byte[idx] <= s_box(byte[idx]). After idx 3, next state is MIX.
REQ-017 MIX: data <= rotl8(data), i.e. {data[23:0],data[31:24]}. Apply the key XOR per REQ-026. Decrement round counter. Next state is DONE if counter reaches 0, else SUB with idx=0.
REQ-018 Latency: 5 cycles per round. If accept occurs in cycle T, out_valid SHALL be first visible in cycle T+5N+1 (N=in_rounds). N=0 gives T+1.
REQ-019 DONE: out_valid=1 and out_data stable until out_ready. On handshake: out_valid=0, in_ready=1, next state IDLE.
REQ-020 in_ready SHALL be 0 in SUB, MIX and DONE. in_valid SHALL be ignored outside IDLE, and in_data/key/in_rounds changes after accept SHALL have no effect.
REQ-021 out_ready while out_valid=0 SHALL have no effect.
REQ-022 in_rounds=15 SHALL complete in exactly 75 work cycles. The counter SHALL NOT wrap.

Reset
REQ-023 rst SHALL asynchronously force: state IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, internal data/key/counter/index all 0.
REQ-024 rst asserted mid-operation (SUB/MIX/DONE) SHALL abort the block with no result emitted. The first accept after reset release SHALL start a fresh block.
REQ-025 out_data SHALL hold its last value after the output handshake until the next DONE or reset.

Configuration
REQ-026 Macro SBOX_ROUND_CTRL_KEY_EN:
- Defined: MIX computes data <= rotl8(data) ^ latched key.
- Undefined: MIX computes data <= rotl8(data) only. The key port remains present but is unused, and no key register is built.

Verification
REQ-027 Reset: rst pulse mid-SUB -> immediately out_valid=0, busy=0, in_ready=1. The next block completes normally.
REQ-028 Zero block: in_data=0x00000000, in_rounds=1, key=0, macro undefined -> out_data=0x01010101 at T+6.
REQ-029 Mixed bytes: in_data=0xA0A0A000, in_rounds=1, macro undefined -> out_data=0x0B0B010B at T+6.
REQ-030 Key: in_data=0x00000000, in_rounds=1, key=0x000000FF, macro defined -> out_data=0x010101FE. With the macro undefined -> 0x01010101.
REQ-031 Pass-through and backpressure: in_rounds=0, in_data=0x12345678 -> out_valid at T+1 with 0x12345678. Hold out_ready=0 for 10 cycles -> out_valid and out_data stable and in_ready=0 throughout. out_ready=1 -> in_ready=1 the next cycle.
REQ-032 Max rounds: in_rounds=15 -> out_valid at T+76. in_valid toggled with new data during processing -> result unaffected.
